// File: rtl/l2_grad.sv
// l2_grad: streams dL/dyHat = 2*(yHat - y) per element under valid/ready and
// accumulates the squared-error loss. Define L2_GRAD_SAT_EN to saturate grad/loss.
module l2_grad #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int size  = 16,
  parameter int width = $clog2(size)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic signed [size-1:0][IL+FL-1:0]   yHat,
  input  logic signed [size-1:0][IL+FL-1:0]   y,
  input  logic        [width:0]               num,
  output logic                                busy,
  output logic                                grad_valid,
  input  logic                                grad_ready,
  output logic signed [IL+FL-1:0]             grad,
  output logic        [width-1:0]             grad_idx,
  output logic signed [IL+FL-1:0]             loss,
  output logic                                done
);

  localparam int W  = IL + FL;
  localparam int AW = 2 * W;
  localparam logic [width:0] NMAX = (width+1)'(size);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t                  r_state, w_next;
  logic signed [W-1:0]     r_yh [size];
  logic signed [W-1:0]     r_y  [size];
  logic        [width:0]   r_n;
  logic        [width-1:0] r_idx_p0;
  logic                    r_vld_p0;
  logic signed [W-1:0]     r_grad_p0;
  logic signed [AW-1:0]    r_acc;

  logic                    w_cap, w_hs, w_last;
  logic        [width:0]   w_n;
  logic        [width-1:0] w_nidx;

  function automatic logic signed [W-1:0] grad_of(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
`ifdef L2_GRAD_SAT_EN
    logic signed [W:0]   d;
    logic signed [W+1:0] g;
    d = {a[W-1], a} - {b[W-1], b};
    g = {d, 1'b0};
    // In range only when the bits above the W-bit sign position agree with it.
    if ((g[W+1:W-1] == 3'b000) || (g[W+1:W-1] == 3'b111))
      return g[W-1:0];
    else if (g[W+1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
`else
    return (a - b) <<< 1;
`endif
  endfunction

  function automatic logic signed [AW-1:0] sq_of(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
    logic signed [W:0]      d;
    logic signed [2*W+1:0]  p;
    d = {a[W-1], a} - {b[W-1], b};
    p = d * d;
    return AW'(p >>> FL);
  endfunction

  function automatic logic signed [W-1:0] loss_of(input logic signed [AW-1:0] acc);
`ifdef L2_GRAD_SAT_EN
    localparam logic signed [AW-1:0] LMAX = AW'((2**(W-1)) - 1);
    // The sum of squares is never negative, so only the positive rail applies.
    return (acc > LMAX) ? {1'b0, {(W-1){1'b1}}} : W'(acc);
`else
    return W'(acc);
`endif
  endfunction

  assign w_n    = (num > NMAX) ? NMAX : num;
  assign w_cap  = (r_state == IDLE) && start;
  assign w_hs   = r_vld_p0 && grad_ready;
  assign w_last = w_hs && ({1'b0, r_idx_p0} == (r_n - (width+1)'(1)));
  assign w_nidx = r_idx_p0 + width'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (w_n != '0) ? STREAM : FINISH;
      STREAM:  if (w_last) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Stage p0: capture and output register holding the presented element
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0  <= 1'b0;
      r_idx_p0  <= '0;
      r_grad_p0 <= '0;
      r_acc     <= '0;
      r_n       <= '0;
    end else if (w_cap) begin
      for (int i = 0; i < size; i++) begin
        r_yh[i] <= $signed(yHat[i]);
        r_y[i]  <= $signed(y[i]);
      end
      r_n       <= w_n;
      r_idx_p0  <= '0;
      r_acc     <= '0;
      r_vld_p0  <= (w_n != '0);
      r_grad_p0 <= grad_of($signed(yHat[0]), $signed(y[0]));
    end else if (w_hs) begin
      r_acc <= r_acc + sq_of(r_yh[r_idx_p0], r_y[r_idx_p0]);
      if (w_last) begin
        r_vld_p0 <= 1'b0;
      end else begin
        r_idx_p0  <= w_nidx;
        r_grad_p0 <= grad_of(r_yh[w_nidx], r_y[w_nidx]);
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FINISH);
  assign grad_valid = r_vld_p0;
  assign grad       = r_grad_p0;
  assign grad_idx   = r_idx_p0;
  assign loss       = loss_of(r_acc);

endmodule

// File: tb/tb_l2_grad.sv
// Randomized bench for l2_grad: a per-pass timeline/value model is built from
// plain arithmetic and checked against the DUT every cycle of the pass.
module tb_l2_grad;
  localparam int IL = 4, FL = 16, SIZE = 16, WIDTH = 4, W = IL + FL;
  localparam int TMAX = 160;

  logic clk = 1'b0;
  logic reset, start, grad_ready;
  logic signed [SIZE-1:0][W-1:0] yHat, y;
  logic [WIDTH:0] num;
  logic busy, grad_valid, done;
  logic signed [W-1:0] grad, loss;
  logic [WIDTH-1:0] grad_idx;

  l2_grad #(.IL(IL), .FL(FL), .size(SIZE), .width(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .yHat(yHat), .y(y), .num(num),
    .busy(busy), .grad_valid(grad_valid), .grad_ready(grad_ready),
    .grad(grad), .grad_idx(grad_idx), .loss(loss), .done(done));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  longint exp_g [SIZE];
  longint exp_loss;
  bit     tl_valid [TMAX], tl_done [TMAX], tl_busy [TMAX], rdy [TMAX];
  int     tl_idx [TMAX];
  int     t0, m_last_t, last_done_t, last_idx;
  bit     m_active = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, cyc - t0 + 1);
    end
  endtask

  // Reduce an exact value to the W-bit output format.
  function automatic longint fit(input longint v);
    longint m;
`ifdef L2_GRAD_SAT_EN
    m = v;
    if (m > 524287) m = 524287;
    if (m < -524288) m = -524288;
`else
    m = v & 64'hFFFFF;
    if (m >= 524288) m = m - 1048576;
`endif
    return m;
  endfunction

  always @(negedge clk) begin
    int t;
    if (m_active) begin
      t = cyc - t0 + 1;
      if (t >= 1 && t <= m_last_t && t < TMAX) begin
        chk("busy", busy, tl_busy[t]);
        chk("grad_valid", grad_valid, tl_valid[t]);
        chk("done", done, tl_done[t]);
        if (tl_valid[t]) begin
          chk("grad_idx", grad_idx, tl_idx[t]);
          chk("grad", grad, exp_g[tl_idx[t]]);
        end
        if (tl_done[t]) chk("loss", loss, exp_loss);
        if (done) last_done_t = t;
        if (grad_valid) last_idx = grad_idx;
      end
    end
  end

  // dmode: 0 ramp i<<FL, 1 extreme values, 2 small random, 3 full random.
  // rmode: 0 ready=1, 1 ready high on odd cycles, 2 random ready.
  task automatic run_pass(input int nreq, input int rmode, input int dmode, input int abort_t);
    int n, pos, t, done_t;
    longint s, d;
    for (int i = 0; i < SIZE; i++) begin
      case (dmode)
        0:       begin yHat[i] = W'(i << FL); y[i] = '0; end
        1:       begin yHat[i] = 20'h7FFFF; y[i] = 20'h80000; end
        2:       begin yHat[i] = W'(int'($urandom_range(0, 8191)) - 4096);
                       y[i]    = W'(int'($urandom_range(0, 8191)) - 4096); end
        default: begin yHat[i] = W'($urandom); y[i] = W'($urandom); end
      endcase
    end
    n = (nreq > SIZE) ? SIZE : nreq;
    s = 0;
    for (int i = 0; i < n; i++) begin
      d = longint'($signed(yHat[i])) - longint'($signed(y[i]));
      exp_g[i] = fit(2 * d);
      s = s + ((d * d) >>> FL);
    end
    exp_loss = fit(s);
    for (int k = 0; k < TMAX; k++) begin
      case (rmode)
        0:       rdy[k] = 1'b1;
        1:       rdy[k] = k[0];
        default: rdy[k] = ($urandom_range(0, 99) < 60) || (k > 80);
      endcase
      tl_valid[k] = 1'b0; tl_done[k] = 1'b0; tl_busy[k] = 1'b0; tl_idx[k] = 0;
    end
    pos = 0;
    t = 1;
    while (pos < n) begin
      tl_valid[t] = 1'b1; tl_idx[t] = pos; tl_busy[t] = 1'b1;
      if (rdy[t]) pos++;
      t++;
    end
    tl_done[t] = 1'b1;
    tl_busy[t] = 1'b1;
    done_t = t;
    m_last_t = (abort_t != 0) ? abort_t : done_t + 1;

    num = (WIDTH+1)'(nreq);
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    last_done_t = -1;
    last_idx = -1;
    m_active = 1'b1;
    for (int k = 1; k <= m_last_t; k++) begin
      grad_ready = rdy[k];
      if (dmode >= 2) begin
        yHat[$urandom_range(0, SIZE-1)] = W'($urandom);
        y[$urandom_range(0, SIZE-1)]    = W'($urandom);
        start = (k <= done_t) && ($urandom_range(0, 3) == 0);
      end
      if (abort_t != 0 && k == abort_t) reset = 1'b1;
      @(posedge clk); #1;
    end
    m_active = 1'b0;
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; grad_ready = 1'b0; yHat = '0; y = '0; num = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", grad_valid, 0);
    chk("rst_grad", grad, 0);
    chk("rst_idx", grad_idx, 0);
    chk("rst_loss", loss, 0);
    chk("rst_done", done, 0);

    // Ramp: 14<<FL exceeds the 20-bit signed range, so it rails or wraps.
    run_pass(4, 0, 0, 0);
    chk("ramp_done_t", last_done_t, 5);
`ifdef L2_GRAD_SAT_EN
    chk("ramp_loss", loss, 524287);
`else
    chk("ramp_loss", loss, -131072);
`endif
    run_pass(4, 1, 0, 0);
    chk("toggle_done_t", last_done_t, 8);
`ifdef L2_GRAD_SAT_EN
    chk("toggle_loss", loss, 524287);
`else
    chk("toggle_loss", loss, -131072);
`endif

    run_pass(0, 0, 2, 0);
    chk("empty_done_t", last_done_t, 1);
    chk("empty_loss", loss, 0);
    chk("empty_no_valid", last_idx, -1);

    run_pass(31, 2, 2, 0);
    chk("clamp_last_idx", last_idx, 15);

    run_pass(4, 0, 1, 0);
`ifdef L2_GRAD_SAT_EN
    chk("ext_grad", grad, 524287);
    chk("ext_loss", loss, 524287);
`else
    chk("ext_grad", grad, -2);
    chk("ext_loss", loss, -128);
`endif

    run_pass(8, 0, 2, 4);
    chk("abort_busy", busy, 0);
    chk("abort_valid", grad_valid, 0);
    chk("abort_loss", loss, 0);
    chk("abort_done", done, 0);
    chk("abort_grad", grad, 0);
    chk("abort_idx", grad_idx, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet_done", done, 0);
      chk("abort_quiet_busy", busy, 0);
    end
    run_pass(8, 2, 3, 0);
    chk("after_abort_last_idx", last_idx, 7);

    for (int p = 0; p < 20; p++)
      run_pass($urandom_range(0, 31), $urandom_range(0, 2), 2 + $urandom_range(0, 1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
